mem_io_responder: RTL and testbench
===================================

# mem_io_responder

Memory-side responder for the CPU's byte-wide memory bus. Holds the 128 KB unified instruction/data RAM and decodes the I/O window at `mem_a[17:16]==2'b11`. It returns read data one cycle after the address and accepts writes in the same cycle. It also buffers UART output in a TX FIFO and UART input in an RX FIFO, exposes a free-running cycle counter, and drives `io_buffer_full` back to the CPU.

## Interface
Parameters:
- `ADDR_W`, 17: RAM address width; RAM holds 2^ADDR_W bytes.
- `TX_DEPTH`, 16: TX FIFO depth in bytes; must be a power of 2 and ≥4.
- `RX_DEPTH`, 16: RX FIFO depth in bytes; must be a power of 2.

Ports:
- `clk_in` in 1: the single clock.
- `rst_in` in 1: asynchronous, active-low reset.
- `mem_a` in 32: byte address from the CPU; bits [17:0] are decoded.
- `mem_wr` in 1: 1 = write, 0 = read. The bus has no idle encoding; every cycle is a read or a write.
- `mem_wdata` in 8: write byte (the CPU's `mem_dout`).
- `mem_rdata` out 8: read byte (the CPU's `mem_din`), registered.
- `io_buffer_full` out 1: TX FIFO near full; the CPU must not issue a 0x30000/0x30004 write while it is high.
- `tx_data` out 8, `tx_valid` out 1, `tx_ready` in 1: UART transmit stream, valid/ready.
- `rx_data` in 8, `rx_valid` in 1: UART receive strobe, one byte per cycle. The source has no backpressure.
- `program_end` out 1: sticky stop flag.

## Operation
Address decode:
- RAM access when `mem_a[17:16]!=2'b11`; the index is `mem_a[ADDR_W-1:0]`.
- I/O access otherwise; only `mem_a[2:0]` is significant in the I/O window.

RAM:
- Write: store `mem_wdata`.
- Read: the byte appears on `mem_rdata` the next cycle.
- Reading and writing the same address in the same cycle is impossible, since there is one access per cycle.
- RAM contents are not reset; they are preloaded by `$readmemh` in simulation.

I/O writes:
- 0x30000: push `mem_wdata` into the TX FIFO. 0x00 is ignored.
- 0x30004: push 0x00 into the TX FIFO and set `program_end`.
- Other I/O addresses: ignored.
- If the TX FIFO is full, the byte is dropped. This is a CPU protocol violation, and the bench flags it.

I/O reads (result registered, next cycle):
- 0x30000: pop the RX FIFO and return the popped byte; returns 0x00 without popping if the FIFO is empty.
- 0x30004: return counter[7:0] and latch all 32 counter bits into the snapshot register `cnt_snap`.
- 0x30005–0x30007: return `cnt_snap` bytes 1–3, so a 4-byte load is coherent.
- Other I/O addresses: return 0x00.

Cycle counter:
- 32 bits, cleared by reset, +1 every cycle, wraps at 2^32.

Flow control:
- `io_buffer_full` = (tx_count ≥ TX_DEPTH−2), registered. This leaves margin for one in-flight write.
- TX pops when `tx_valid && tx_ready`. `tx_valid` = !tx_empty, and `tx_data` = FIFO head (first-word-fall-through).
- RX pushes on `rx_valid`. A push into a full RX FIFO drops the byte.

Simultaneous events:
- Push and pop on a FIFO in the same cycle: both take effect and the count is unchanged.
- This holds even when the FIFO is full: the pop frees the slot, so the push is accepted.
- Push into an empty RX FIFO while reading 0x30000: returns 0x00; the byte stays queued.

## Timing
- Read latency is exactly 1 cycle for both RAM and I/O. Write latency is 0; the effect is visible to a read in the next cycle.
- `io_buffer_full` lags the FIFO count by 1 cycle.
- `tx_valid` rises the cycle after the first push into an empty FIFO.
- Reset (async assert, sync release):
  - `mem_rdata`=0, `tx_valid`=0, `io_buffer_full`=0, `program_end`=0.
  - counter=0, `cnt_snap`=0, both FIFOs empty.
- Reset mid-transfer discards FIFO contents. It does not corrupt RAM.

## Configuration
- `MEM_IO_CYCLE_CNT_EN` defined: the 32-bit counter and snapshot exist and behave as above.
- Not defined: the counter and snapshot are removed, and reads of 0x30004–0x30007 return 0x00.
- All other behaviour is identical in both builds.

## Structure
- `config.v` gains:
  - `IO_BASE` 18'h30000, `IO_PORT_UART` 3'd0, `IO_PORT_CNT` 3'd4.
  - `Byte_Len` [7:0].
- Natural sub-module: `byte_fifo`, parameterized by depth. It is synchronous, first-word-fall-through, provides push/pop/count/full/empty, and is instantiated twice (TX, RX).

## Test plan
- RAM round trip: write 0xA5 to 0x01234, then read 0x01234 → `mem_rdata`=0xA5 the following cycle; other addresses unchanged.
- UART output: write 0x48 then 0x00 to 0x30000, with `tx_ready`=1 → exactly one `tx_valid` beat carrying 0x48; the 0x00 never appears.
- Backpressure: `tx_ready`=0, write TX_DEPTH−2 bytes → `io_buffer_full`=1 one cycle after the last push. Raise `tx_ready` → it falls once the count is below TX_DEPTH−2; bytes are emitted in order.
- Counter: 100 cycles after reset release, read 0x30004–0x30007 over 4 consecutive cycles → bytes reassemble to the snapshot value, not four different counter values. Repeat without `MEM_IO_CYCLE_CNT_EN` → all reads return 0x00.
- RX: pulse `rx_valid` with 0x31, 0x32 → two reads of 0x30000 return 0x31, 0x32, and a third read returns 0x00.
- Stop and reset: write 0x30004 → `program_end`=1 and one 0x00 on tx. Assert `rst_in`=0 mid-stream → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/mem_io_responder_pkg.sv
// Shared constants and types for the memory/IO responder.
// Used by both builds; the cycle counter is gated by MEM_IO_CYCLE_CNT_EN in the top.
package mem_io_responder_pkg;

  localparam int BYTE_LEN = 8;
  typedef logic [BYTE_LEN-1:0] byte_t;

  localparam logic [17:0] IO_BASE      = 18'h30000;
  localparam logic [2:0]  IO_PORT_UART = 3'd0;
  localparam logic [2:0]  IO_PORT_CNT  = 3'd4;

  function automatic logic is_io(input logic [17:0] a);
    return a[17:16] == IO_BASE[17:16];
  endfunction

endpackage

// File: rtl/mem_io_responder_fifo.sv
// Synchronous first-word-fall-through byte FIFO; a pop frees a slot for a same-cycle push.
import mem_io_responder_pkg::*;

module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push,
  input  byte_t                    din,
  input  logic                     pop,
  output byte_t                    dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  byte_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mem_io_responder.sv
// Byte-wide memory/IO responder: RAM, UART TX/RX FIFOs, optional cycle counter.
// Define MEM_IO_CYCLE_CNT_EN to include the 32-bit cycle counter and its snapshot.
import mem_io_responder_pkg::*;

module mem_io_responder #(
  parameter int ADDR_W   = 17,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  byte_t       mem_wdata,
  output byte_t       mem_rdata,
  output logic        io_buffer_full,
  output byte_t       tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  byte_t       rx_data,
  input  logic        rx_valid,
  output logic        program_end
);

  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;
  // One slot of headroom covers a write already in flight when the flag rises.
  localparam logic [TCW-1:0] TX_HIGH = TCW'(TX_DEPTH - 2);

  logic              io_acc;
  logic [2:0]        port;
  logic [ADDR_W-1:0] ram_idx;
  logic              uart_wr;
  logic              cnt_wr;
  logic              tx_push;
  byte_t             tx_din;
  logic              tx_empty;
  logic              tx_full;
  logic [TCW-1:0]    tx_count;
  logic              rx_pop;
  byte_t             rx_head;
  logic              rx_empty;
  logic              rx_full;
  logic [RCW-1:0]    rx_count;
  logic              unused_sigs;

  byte_t ram [2**ADDR_W];

  assign io_acc   = is_io(mem_a[17:0]);
  assign port     = mem_a[2:0];
  assign ram_idx  = mem_a[ADDR_W-1:0];
  assign uart_wr  = mem_wr && io_acc && (port == IO_PORT_UART);
  assign cnt_wr   = mem_wr && io_acc && (port == IO_PORT_CNT);
  assign tx_push  = (uart_wr && (mem_wdata != '0)) || cnt_wr;
  assign tx_din   = cnt_wr ? '0 : mem_wdata;
  assign tx_valid = !tx_empty;
  assign rx_pop   = !mem_wr && io_acc && (port == IO_PORT_UART);

  assign unused_sigs = ^{mem_a[31:18], tx_full, rx_full, rx_count};

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (tx_push),
    .din    (tx_din),
    .pop    (tx_ready),
    .dout   (tx_data),
    .count  (tx_count),
    .full   (tx_full),
    .empty  (tx_empty)
  );

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (rx_valid),
    .din    (rx_data),
    .pop    (rx_pop),
    .dout   (rx_head),
    .count  (rx_count),
    .full   (rx_full),
    .empty  (rx_empty)
  );

  always_ff @(posedge clk_in) begin
    if (mem_wr && !io_acc) ram[ram_idx] <= mem_wdata;
  end

`ifdef MEM_IO_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] cnt_snap;

  // Reading the low byte freezes the whole count so the upper bytes match it.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cycle_cnt <= '0;
      cnt_snap  <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (!mem_wr && io_acc && (port == IO_PORT_CNT)) cnt_snap <= cycle_cnt;
    end
  end
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_rdata      <= '0;
      io_buffer_full <= 1'b0;
      program_end    <= 1'b0;
    end else begin
      io_buffer_full <= (tx_count >= TX_HIGH);
      if (cnt_wr) program_end <= 1'b1;
      if (!mem_wr) begin
        if (!io_acc) begin
          mem_rdata <= ram[ram_idx];
        end else begin
          case (port)
            IO_PORT_UART: mem_rdata <= rx_empty ? '0 : rx_head;
`ifdef MEM_IO_CYCLE_CNT_EN
            IO_PORT_CNT:  mem_rdata <= cycle_cnt[7:0];
            3'd5:         mem_rdata <= cnt_snap[15:8];
            3'd6:         mem_rdata <= cnt_snap[23:16];
            3'd7:         mem_rdata <= cnt_snap[31:24];
`endif
            default:      mem_rdata <= '0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Randomized bench for mem_io_responder against a queue-based reference model.
module tb_mem_io_responder;

  localparam int TX_D = 16;
  localparam int RX_D = 16;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [31:0] mem_a = 32'h0;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_wdata = 8'h0;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_valid = 1'b0;
  logic        tx_ready = 1'b0;
  logic [7:0]  mem_rdata;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        program_end;

  int vectors = 0;
  int miscompares = 0;

  mem_io_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .program_end    (program_end)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFOs as queues, RAM as a sparse map of written bytes.
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  ram_m[int];
  logic [31:0] m_cnt, m_snap;
  logic [7:0]  e_rdata;
  logic        e_full, e_pend, r_chk;
  int          m_tsz;
  logic        m_io, m_tpush;
  logic [2:0]  m_port;
  logic [7:0]  m_tbyte;
  int          m_idx;

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tx_q.delete();
      rx_q.delete();
      m_cnt = 0; m_snap = 0; e_rdata = 0;
      e_full = 0; e_pend = 0; r_chk = 1;
    end else begin
      m_tsz  = tx_q.size();
      m_io   = (mem_a[17:16] == 2'b11);
      m_port = mem_a[2:0];
      m_idx  = int'(mem_a[16:0]);
      r_chk  = 0;
      if (tx_ready && m_tsz > 0) void'(tx_q.pop_front());
      m_tpush = 0; m_tbyte = 0;
      if (mem_wr && m_io && m_port == 3'd0 && mem_wdata != 8'h0) begin m_tpush = 1; m_tbyte = mem_wdata; end
      if (mem_wr && m_io && m_port == 3'd4) begin m_tpush = 1; e_pend = 1; end
      if (m_tpush) begin
        chk("tx_overflow", 32'(tx_q.size() < TX_D), 32'd1);
        if (tx_q.size() < TX_D) tx_q.push_back(m_tbyte);
      end
      if (!mem_wr) begin
        if (!m_io) begin
          if (ram_m.exists(m_idx)) begin e_rdata = ram_m[m_idx]; r_chk = 1; end
        end else begin
          r_chk = 1;
          e_rdata = 0;
          case (m_port)
            3'd0: if (rx_q.size() > 0) e_rdata = rx_q.pop_front();
`ifdef MEM_IO_CYCLE_CNT_EN
            3'd4: begin e_rdata = m_cnt[7:0]; m_snap = m_cnt; end
            3'd5: e_rdata = m_snap[15:8];
            3'd6: e_rdata = m_snap[23:16];
            3'd7: e_rdata = m_snap[31:24];
`endif
            default: e_rdata = 0;
          endcase
        end
      end else if (!m_io) begin
        ram_m[m_idx] = mem_wdata;
      end
      if (rx_valid && rx_q.size() < RX_D) rx_q.push_back(rx_data);
      e_full = (m_tsz >= TX_D - 2);
      m_cnt  = m_cnt + 1;
    end
  end

  always @(negedge clk_in) begin
    chk("tx_valid", 32'(tx_valid), 32'(tx_q.size() > 0));
    if (tx_q.size() > 0) chk("tx_data", 32'(tx_data), 32'(tx_q[0]));
    chk("io_buffer_full", 32'(io_buffer_full), 32'(e_full));
    chk("program_end", 32'(program_end), 32'(e_pend));
    if (r_chk) chk("mem_rdata", 32'(mem_rdata), 32'(e_rdata));
  end

  task automatic cyc(input logic wr, input logic [31:0] a, input logic [7:0] d);
    mem_wr = wr; mem_a = a; mem_wdata = d;
    @(posedge clk_in);
    #1;
  endtask

  logic [7:0]  b [4];
  logic [31:0] r;
  logic [31:0] a;
  logic [2:0]  p;
  logic        w;
  logic [7:0]  d;
  logic [31:0] exp_snap;

  initial begin
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_rdata", 32'(mem_rdata), 32'h0);
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_full", 32'(io_buffer_full), 32'h0);
    chk("rst_pend", 32'(program_end), 32'h0);
    rst_in = 1'b1;

    // Counter: 100 idle cycles, then a coherent 4-byte read.
    repeat (100) cyc(1'b0, 32'h0001_1200, 8'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 32'h0003_0004 + 32'(i), 8'h0);
      b[i] = mem_rdata;
    end
`ifdef MEM_IO_CYCLE_CNT_EN
    exp_snap = 32'd100;
`else
    exp_snap = 32'd0;
`endif
    chk("cnt_byte0", 32'(b[0]), exp_snap & 32'hFF);
    chk("cnt_snap", {b[3], b[2], b[1], b[0]}, exp_snap);

    // RAM round trip
    cyc(1'b1, 32'h0000_1234, 8'hA5);
    cyc(1'b1, 32'h0000_1235, 8'h5A);
    cyc(1'b0, 32'h0000_1234, 8'h0);
    chk("ram_rd_1234", 32'(mem_rdata), 32'hA5);
    cyc(1'b0, 32'h0000_1235, 8'h0);
    chk("ram_rd_1235", 32'(mem_rdata), 32'h5A);

    // UART output, zero byte suppressed
    tx_ready = 1'b1;
    cyc(1'b1, 32'h0003_0000, 8'h48);
    chk("tx_first_valid", 32'(tx_valid), 32'h1);
    chk("tx_first_data", 32'(tx_data), 32'h48);
    cyc(1'b1, 32'h0003_0000, 8'h00);
    chk("tx_zero_dropped", 32'(tx_valid), 32'h0);

    // RX queue and empty read
    rx_valid = 1'b1; rx_data = 8'h31;
    cyc(1'b0, 32'h0001_1200, 8'h0);
    rx_data = 8'h32;
    cyc(1'b0, 32'h0001_1200, 8'h0);
    rx_valid = 1'b0;
    cyc(1'b0, 32'h0003_0000, 8'h0);
    chk("rx_rd1", 32'(mem_rdata), 32'h31);
    cyc(1'b0, 32'h0003_0000, 8'h0);
    chk("rx_rd2", 32'(mem_rdata), 32'h32);
    cyc(1'b0, 32'h0003_0000, 8'h0);
    chk("rx_rd_empty", 32'(mem_rdata), 32'h0);

    // Backpressure: TX_D-2 bytes with the sink stalled
    tx_ready = 1'b0;
    for (int i = 0; i < TX_D - 2; i++) cyc(1'b1, 32'h0003_0000, 8'h10 + 8'(i));
    chk("full_lag", 32'(io_buffer_full), 32'h0);
    cyc(1'b0, 32'h0001_1200, 8'h0);
    chk("full_set", 32'(io_buffer_full), 32'h1);
    chk("tx_head", 32'(tx_data), 32'h10);
    tx_ready = 1'b1;
    repeat (TX_D + 2) cyc(1'b0, 32'h0001_1200, 8'h0);
    chk("full_clear", 32'(io_buffer_full), 32'h0);

    // Stop flag, then reset mid-stream
    tx_ready = 1'b0;
    cyc(1'b1, 32'h0003_0004, 8'h77);
    chk("pend_set", 32'(program_end), 32'h1);
    chk("stop_tx_valid", 32'(tx_valid), 32'h1);
    chk("stop_tx_data", 32'(tx_data), 32'h0);
    cyc(1'b1, 32'h0003_0000, 8'h55);
    #2 rst_in = 1'b0;
    #1;
    chk("mid_rst_rdata", 32'(mem_rdata), 32'h0);
    chk("mid_rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("mid_rst_full", 32'(io_buffer_full), 32'h0);
    chk("mid_rst_pend", 32'(program_end), 32'h0);
    @(posedge clk_in);
    #1 rst_in = 1'b1;
    cyc(1'b0, 32'h0000_1234, 8'h0);
    chk("ram_after_rst", 32'(mem_rdata), 32'hA5);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      r = $urandom();
      p = ($urandom_range(1, 0) == 1) ? 3'd0 : 3'($urandom_range(7, 0));
      if ($urandom_range(1, 0) == 1)
        a = {r[31:18], 2'b00, 16'h1200 + 16'($urandom_range(63, 0))};
      else
        a = {r[31:18], 2'b11, r[15:3], p};
      w = ($urandom_range(1, 0) == 1);
      if (w && a[17:16] == 2'b11 && p == 3'd4 && $urandom_range(15, 0) != 0) p = 3'd0;
      if (a[17:16] == 2'b11) a[2:0] = p;
      if (w && a[17:16] == 2'b11 && (p == 3'd0 || p == 3'd4) && e_full) w = 1'b0;
      d = ($urandom_range(7, 0) == 0) ? 8'h00 : 8'($urandom());
      rx_valid = ($urandom_range(9, 0) < 3);
      rx_data  = 8'($urandom());
      tx_ready = ($urandom_range(1, 0) == 1);
      cyc(w, a, d);
    end

    rx_valid = 1'b0;
    @(negedge clk_in);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
